// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller.
//   OP_*        : command opcodes carried in the top two bits of every frame
//   FRAME_W     : serial frame width {op, byte}
//   DATA_W      : payload / read-back byte width
//   CNT_W       : width of the shared bit counter (covers SHIFT and READ)
//   state_t     : controller FSM encoding, also exported on the debug port
package spi_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

    // Last counter value in SHIFT (bit 0 of the frame) and in READ (the
    // finishing cycle after the eighth MISO sample).
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Datapath shifters for the SPI master.
//   clk, rst   : system clock, synchronous active-high reset
//   load       : capture load_word into the TX shifter (also clears RX)
//   load_word  : {op, byte} frame word
//   tx_shift   : advance the TX shifter one bit (MSB out first)
//   tx_bit     : current MSB of the TX shifter
//   rx_shift   : shift rx_bit into the RX byte from the right
//   rx_bit     : serial input bit (MISO)
//   rx_byte    : captured byte, first bit shifted in ends up in bit 7
module spi_shift_reg
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_word,
    input  logic               tx_shift,
    output logic               tx_bit,
    input  logic               rx_shift,
    input  logic               rx_bit,
    output logic [DATA_W-1:0]  rx_byte
);

    logic [FRAME_W-1:0] tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= '0;
            rx_byte <= '0;
        end else begin
            if (load) begin
                tx_q    <= load_word;
                rx_byte <= '0;
            end else begin
                if (tx_shift) begin
                    tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
                end
                // Only enabled in READ, so an undriven MISO never reaches rx_byte.
                if (rx_shift) begin
                    rx_byte <= {rx_byte[DATA_W-2:0], rx_bit};
                end
            end
        end
    end

    assign tx_bit = tx_q[FRAME_W-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI initiator: takes one {op, byte} command at a time, sends it
// as a 10-bit MSB-first frame under SS_n, and for RD_DATA frames captures
// eight MISO bits and returns them on a one-cycle response strobe.
//   clk, rst   : system clock, synchronous active-high reset
//   cmd_valid  : command offered; cmd_ready high only while IDLE
//   cmd_op     : 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//   cmd_data   : address/data byte (shifted out even for RD_DATA)
//   rsp_valid  : one-cycle pulse when an RD_DATA byte is available
//   rsp_data   : last captured MISO byte, held until the next rsp_valid
//   busy       : high from accept until the inter-frame gap has elapsed
//   SS_n, MOSI : registered slave select (active low) and serial data out
//   MISO       : serial data from the slave, sampled only in READ
//   state_dbg  : current FSM state
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_op/cmd_data are sampled only at that edge and never again mid-frame.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_WAIT    = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO,
    output state_t            state_dbg
);

    localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
    logic                rd_frame, rd_frame_n;
    logic                ss_n_q, ss_n_n;
    logic                mosi_q, mosi_n;
    logic                rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_n;

    logic                load, tx_shift, rx_shift, tx_bit;
    logic [DATA_W-1:0]   rx_byte;

    spi_shift_reg u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_word ({cmd_op, cmd_data}),
        .tx_shift  (tx_shift),
        .tx_bit    (tx_bit),
        .rx_shift  (rx_shift),
        .rx_bit    (MISO),
        .rx_byte   (rx_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            rd_frame    <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            wait_cnt    <= wait_cnt_n;
            gap_cnt     <= gap_cnt_n;
            rd_frame    <= rd_frame_n;
            ss_n_q      <= ss_n_n;
            mosi_q      <= mosi_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_data_q  <= rsp_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        wait_cnt_n  = wait_cnt;
        gap_cnt_n   = gap_cnt;
        rd_frame_n  = rd_frame;
        ss_n_n      = ss_n_q;
        mosi_n      = mosi_q;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data_q;
        load        = 1'b0;
        tx_shift    = 1'b0;
        rx_shift    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load       = 1'b1;
                    rd_frame_n = (cmd_op == OP_RD_DATA);
                    ss_n_n     = 1'b0;
                    mosi_n     = 1'b0;
                    state_n    = ST_START;
                end
            end
            // One quiet cycle with SS_n low before the first bit; the slave
            // uses it for its command check.
            ST_START: begin
                tx_shift  = 1'b1;
                mosi_n    = tx_bit;
                bit_cnt_n = '0;
                state_n   = ST_SHIFT;
            end
            // bit_cnt counts bits already on MOSI; bit 0 goes out when it reaches 9.
            ST_SHIFT: begin
                if (bit_cnt == SHIFT_LAST) begin
                    mosi_n = 1'b0;
                    if (rd_frame) begin
                        wait_cnt_n = '0;
                        state_n    = ST_WAIT;
                    end else begin
                        ss_n_n    = 1'b1;
                        gap_cnt_n = '0;
                        state_n   = ST_GAP;
                    end
                end else begin
                    tx_shift  = 1'b1;
                    mosi_n    = tx_bit;
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = ST_READ;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            // Eight sampling edges (bit_cnt 0..7), then one edge that publishes
            // the byte and releases SS_n.
            ST_READ: begin
                if (bit_cnt == READ_LAST) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = rx_byte;
                    ss_n_n      = 1'b1;
                    gap_cnt_n   = '0;
                    state_n     = ST_GAP;
                end else begin
                    rx_shift  = 1'b1;
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl. Two DUTs (RD_WAIT=1/GAP=2 and RD_WAIT=3/GAP=1)
// run the same command list. Each has a behavioural slave with a RAM and a
// frame-level model that predicts every output from cycles-since-accept.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    bit   force_en = 1'b0;
    logic [7:0] force_byte = 8'h00;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        int         dly;
    } cmd_t;

    cmd_t cmds[$];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] data, input int dly);
        cmd_t c;
        c.op = op;
        c.data = data;
        c.dly = dly;
        cmds.push_back(c);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int RW_P   = (gi == 0) ? 1 : 3;
        localparam int G_P    = (gi == 0) ? 2 : 1;
        localparam int RD_LEN = 20 + RW_P;

        logic       cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
        logic [1:0] cmd_op;
        logic [7:0] cmd_data, rsp_data;
        state_t     state_dbg;

        spi_master_ctrl #(.RD_WAIT(RW_P), .GAP_CYCLES(G_P)) u_dut (
            .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
            .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
            .rsp_data(rsp_data), .busy(busy), .SS_n(ss_n), .MOSI(mosi),
            .MISO(miso), .state_dbg(state_dbg)
        );

        // Frame-level model: p = cycles since accept (-1 when idle).
        int         p = -1;
        bit         acc = 1'b0;
        logic       m_rd = 1'b0;
        logic [9:0] m_word = '0;
        logic [7:0] m_mem[256];
        logic [7:0] m_addr = '0;
        logic [7:0] exp_rsp_data = '0;

        // Behavioural slave.
        int         c = -1;
        bit         s_rd = 1'b0;
        logic [9:0] s_sh = '0;
        logic [7:0] s_mem[256];
        logic [7:0] s_addr = '0;
        logic [7:0] s_rbyte = '0;

        // Waveform monitors.
        int         low_len = 0, high_len = 0, last_low = 0;
        int         hr_n = 0, hr_min = 0, hr_max = 0, rsp_cnt = 0;
        logic [9:0] mosi_cap = '0;

        int next_idx = 0;
        int wcnt = 0;

        initial begin
            for (int i = 0; i < 256; i++) begin
                m_mem[i] = 8'h00;
                s_mem[i] = 8'h00;
            end
        end

        always @(posedge clk) begin
            acc = 1'b0;
            if (rst) begin
                p = -1;
                exp_rsp_data = 8'h00;
            end else if (p < 0) begin
                if (cmd_valid) begin
                    p = 0;
                    acc = 1'b1;
                    m_word = {cmd_op, cmd_data};
                    m_rd = (cmd_op == OP_RD_DATA);
                end
            end else begin
                p++;
                if (p == 11) begin
                    case (m_word[9:8])
                        OP_WR_ADDR: m_addr = m_word[7:0];
                        OP_WR_DATA: m_mem[m_addr] = m_word[7:0];
                        OP_RD_ADDR: m_addr = m_word[7:0];
                        default: ;
                    endcase
                end
                if (m_rd && p == RD_LEN) exp_rsp_data = force_en ? force_byte : m_mem[m_addr];
                if (p == (m_rd ? RD_LEN : 11) + G_P) p = -1;
            end
        end

        initial begin
            cmd_valid = 1'b0;
            cmd_op = 2'b00;
            cmd_data = 8'h00;
            forever begin
                @(posedge clk);
                #1;
                if (acc) cmd_valid = 1'b0;
                if (!cmd_valid && next_idx < cmds.size()) begin
                    if (wcnt < cmds[next_idx].dly) wcnt++;
                    else begin
                        cmd_op = cmds[next_idx].op;
                        cmd_data = cmds[next_idx].data;
                        cmd_valid = 1'b1;
                        next_idx++;
                        wcnt = 0;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (ss_n !== 1'b0) begin
                c = -1;
                s_rd = 1'b0;
            end else begin
                c++;
                if (c >= 1 && c <= 10) s_sh = {s_sh[8:0], mosi};
                if (c == 10) begin
                    case (s_sh[9:8])
                        OP_WR_ADDR: s_addr = s_sh[7:0];
                        OP_WR_DATA: s_mem[s_addr] = s_sh[7:0];
                        OP_RD_ADDR: s_addr = s_sh[7:0];
                        default: begin
                            s_rd = 1'b1;
                            s_rbyte = force_en ? force_byte : s_mem[s_addr];
                        end
                    endcase
                end
            end
            if (s_rd && c >= 11 + RW_P && c <= 18 + RW_P) miso = s_rbyte[7 - (c - 11 - RW_P)];
            else miso = 1'($urandom_range(0, 1));
        end

        always @(negedge clk) begin
            if (ss_n === 1'b0) begin
                if (high_len > 0) begin
                    if (hr_n > 0) begin
                        if (hr_n == 1 || high_len < hr_min) hr_min = high_len;
                        if (hr_n == 1 || high_len > hr_max) hr_max = high_len;
                    end
                    hr_n++;
                end
                high_len = 0;
                low_len++;
                if (low_len >= 2 && low_len <= 11) mosi_cap = {mosi_cap[8:0], mosi};
            end else begin
                if (low_len > 0) last_low = low_len;
                low_len = 0;
                high_len++;
            end
            if (rsp_valid === 1'b1) rsp_cnt++;
        end

        int   e_len;
        logic e_ss, e_mosi, e_busy, e_rdy, e_rv;
        always @(negedge clk) begin
            if (chk_en) begin
                e_len  = m_rd ? RD_LEN : 11;
                e_ss   = !(p >= 0 && p < e_len);
                e_mosi = (p >= 1 && p <= 10) ? m_word[10 - p] : 1'b0;
                e_busy = (p >= 0);
                e_rdy  = (p < 0) && !rst;
                e_rv   = (p >= 0) && m_rd && (p == RD_LEN);
                check($sformatf("ss_n_i%0d", gi), 32'(ss_n), 32'(e_ss));
                check($sformatf("mosi_i%0d", gi), 32'(mosi), 32'(e_mosi));
                check($sformatf("busy_i%0d", gi), 32'(busy), 32'(e_busy));
                check($sformatf("cmd_ready_i%0d", gi), 32'(cmd_ready), 32'(e_rdy));
                check($sformatf("rsp_valid_i%0d", gi), 32'(rsp_valid), 32'(e_rv));
                check($sformatf("rsp_data_i%0d", gi), 32'(rsp_data), 32'(exp_rsp_data));
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(g_inst[0].next_idx == cmds.size() && g_inst[1].next_idx == cmds.size() &&
                 g_inst[0].p < 0 && g_inst[1].p < 0 &&
                 !g_inst[0].cmd_valid && !g_inst[1].cmd_valid) && n < 4000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({"idle_timeout_", tag}, 32'(n < 4000), 32'd1);
        @(negedge clk);
        #1;
    endtask

    int rc0, rc1;

    initial begin
        // Reset with a command already offered: reset must win.
        push_cmd(OP_WR_ADDR, 8'hFF, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ss_n", 32'(g_inst[0].ss_n), 32'd1);
        check("rst_mosi", 32'(g_inst[0].mosi), 32'd0);
        check("rst_rsp_valid", 32'(g_inst[0].rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(g_inst[0].rsp_data), 32'h00);
        check("rst_busy", 32'(g_inst[0].busy), 32'd0);
        check("rst_state", 32'(g_inst[0].state_dbg), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready_i0", 32'(g_inst[0].cmd_ready), 32'd1);
        check("rst_cmd_ready_i1", 32'(g_inst[1].cmd_ready), 32'd1);

        // WR_ADDR FF: 11 low cycles, MOSI 0,0 then eight ones.
        wait_idle("wr_addr");
        check("wr_addr_low_len_i0", 32'(g_inst[0].last_low), 32'd11);
        check("wr_addr_low_len_i1", 32'(g_inst[1].last_low), 32'd11);
        check("wr_addr_mosi_i0", 32'(g_inst[0].mosi_cap), 32'h0FF);

        // RAM round trip through the slave.
        rc0 = g_inst[0].rsp_cnt;
        rc1 = g_inst[1].rsp_cnt;
        push_cmd(OP_WR_DATA, 8'hA5, 0);
        push_cmd(OP_RD_ADDR, 8'hFF, 0);
        push_cmd(OP_RD_DATA, 8'h00, 0);
        wait_idle("ram");
        check("ram_rsp_data_i0", 32'(g_inst[0].rsp_data), 32'hA5);
        check("ram_rsp_data_i1", 32'(g_inst[1].rsp_data), 32'hA5);
        check("ram_rsp_cnt_i0", 32'(g_inst[0].rsp_cnt - rc0), 32'd1);
        check("ram_rsp_cnt_i1", 32'(g_inst[1].rsp_cnt - rc1), 32'd1);

        // Fixed MISO pattern, both turnaround settings.
        force_en = 1'b1;
        force_byte = 8'h3C;
        push_cmd(OP_RD_DATA, 8'h5A, 0);
        wait_idle("miso_3c");
        force_en = 1'b0;
        check("miso_3c_i0", 32'(g_inst[0].rsp_data), 32'h3C);
        check("miso_3c_i1", 32'(g_inst[1].rsp_data), 32'h3C);
        check("rd_low_len_i0", 32'(g_inst[0].last_low), 32'd21);
        check("rd_low_len_i1", 32'(g_inst[1].last_low), 32'd23);

        // Back-to-back: SS_n-high spacing is the GAP cycles plus the IDLE accept cycle.
        g_inst[0].hr_n = 0;
        g_inst[1].hr_n = 0;
        push_cmd(OP_WR_ADDR, 8'h12, 0);
        push_cmd(OP_WR_DATA, 8'h34, 0);
        push_cmd(OP_RD_DATA, 8'h00, 0);
        wait_idle("b2b");
        check("b2b_frames_i0", 32'(g_inst[0].hr_n), 32'd3);
        check("b2b_gap_min_i0", 32'(g_inst[0].hr_min), 32'd3);
        check("b2b_gap_max_i0", 32'(g_inst[0].hr_max), 32'd3);
        check("b2b_gap_min_i1", 32'(g_inst[1].hr_min), 32'd2);
        check("b2b_gap_max_i1", 32'(g_inst[1].hr_max), 32'd2);
        check("b2b_rsp_i0", 32'(g_inst[0].rsp_data), 32'h34);

        // Reset while bit 5 is on MOSI: frame dropped, RAM untouched.
        rc0 = g_inst[0].rsp_cnt;
        push_cmd(OP_WR_DATA, 8'h5A, 0);
        begin
            int n;
            n = 0;
            while (g_inst[0].p != 5 && n < 200) begin
                @(posedge clk);
                #2;
                n++;
            end
            check("abort_reach_bit5", 32'(n < 200), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ss_n_i0", 32'(g_inst[0].ss_n), 32'd1);
        check("abort_ss_n_i1", 32'(g_inst[1].ss_n), 32'd1);
        push_cmd(OP_RD_ADDR, 8'h12, 0);
        push_cmd(OP_RD_DATA, 8'h00, 0);
        wait_idle("abort");
        check("abort_rsp_data_i0", 32'(g_inst[0].rsp_data), 32'h34);
        check("abort_rsp_data_i1", 32'(g_inst[1].rsp_data), 32'h34);
        check("abort_rsp_cnt_i0", 32'(g_inst[0].rsp_cnt - rc0), 32'd1);

        // Randomised command stream with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            push_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : 0);
        end
        wait_idle("random");

        // Reset pulse while idle, then one more read.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        push_cmd(OP_RD_DATA, 8'h00, 0);
        wait_idle("post_idle_rst");

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
